// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register carrying CHANNELS x WIDTH-bit fields with a
// valid/ready handshake, synchronous flush, optional 2-entry skid buffer and a
// saturating count of stalled output cycles.
module pipe_stage_buf #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                    state_q, state_d;
  logic [CHANNELS*WIDTH-1:0] main_q, skid_q;
  logic                      accept, pop;
  logic                      load_main, load_skid, main_from_skid, clr;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  // Next-state and datapath load controls; flush wins over any handshake.
  always_comb begin
    accept         = in_valid && in_ready;
    pop            = out_valid && out_ready;
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    clr            = 1'b0;
    if (flush) begin
      state_d = EMPTY;
      clr     = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Occupancy decoded straight from the state.
  always_comb begin
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State and data registers; every field (including PC) is cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (load_main) main_q <= main_from_skid ? skid_q : in_data;
        if (load_skid) skid_q <= in_data;
      end
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;
      // Registered ready: low only while both entries are held, so out_ready
      // never reaches in_ready combinationally.
      always_ff @(posedge clk) begin
        if (reset) rdy_q <= 1'b1;
        else       rdy_q <= (state_d != TWO);
      end
      assign in_ready = rdy_q;
    end else begin : g_single
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: three instances (skid, single
// register, skid with 4-bit stall counter) share the stimulus; a queue-based
// FIFO model tracks the instance selected by each test.
module tb_pipe_stage_buf;
  localparam int W  = 32;
  localparam int C  = 5;
  localparam int DW = W * C;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          ir1, ov1, ir0, ov0, irs, ovs;
  logic [DW-1:0] od1, od0, ods;
  logic [1:0]    occ1, occ0, occs;
  logic [15:0]   sc1, sc0;
  logic [3:0]    scs;

  logic          ir, ov;
  logic [DW-1:0] od;
  logic [1:0]    occ;
  logic [15:0]   sc;

  int sel = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] junk;
  int            m_stall = 0;
  bit            m_zero = 1'b1;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .CHANNELS(C), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1), .stall_cnt(sc1));

  pipe_stage_buf #(.WIDTH(W), .CHANNELS(C), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ0), .stall_cnt(sc0));

  pipe_stage_buf #(.WIDTH(W), .CHANNELS(C), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irs),
    .in_data(in_data), .out_valid(ovs), .out_ready(out_ready), .out_data(ods),
    .occupancy(occs), .stall_cnt(scs));

  always_comb begin
    case (sel)
      1: begin ir = ir0; ov = ov0; od = od0; occ = occ0; sc = sc0; end
      2: begin ir = irs; ov = ovs; od = ods; occ = occs; sc = {12'b0, scs}; end
      default: begin ir = ir1; ov = ov1; od = od1; occ = occ1; sc = sc1; end
    endcase
  end

  // Capacity 1 with pass-through ready for the single register, capacity 2 otherwise.
  function automatic bit model_ready();
    if (sel == 1) return (q.size() == 0) || out_ready;
    return q.size() < 2;
  endfunction

  // One clock of the reference FIFO using the inputs currently driven.
  task automatic cyc();
    bit acc, pp;
    int smax;
    smax = (sel == 2) ? 15 : 65535;
    pp   = (q.size() > 0) && out_ready;
    acc  = in_valid && model_ready();
    if (q.size() > 0 && !out_ready && m_stall != smax) m_stall++;
    @(posedge clk);
    if (reset) begin
      q.delete(); m_stall = 0; m_zero = 1'b1;
    end else if (flush) begin
      q.delete(); m_zero = 1'b1;
    end else begin
      if (pp) junk = q.pop_front();
      if (acc) begin q.push_back(in_data); m_zero = 1'b0; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    in_valid = 1'b1; in_data = {C{32'hDEAD_BEEF}};
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov); end
    n_checks++; if (od !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", od); end
    n_checks++; if (od[2*W +: W] !== 32'h0) begin n_fail++; $display("FAIL reset_pc_channel got %h want 0", od[2*W +: W]); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occ); end
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir); end
    n_checks++; if (sc !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", sc); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        in_valid = 1'b1; exp = {C{32'(k)}}; in_data = exp;
        #1;
        n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready sel=%0d k=%0d got %b want 1", s, k, ir); end
        cyc();
        n_checks++; if (ov !== 1'b1 || od !== exp) begin n_fail++; $display("FAIL stream_data sel=%0d k=%0d got v=%b d=%h want v=1 d=%h", s, k, ov, od, exp); end
      end
      in_valid = 1'b0;
      cyc();
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL stream_drain sel=%0d got %b want 0", s, ov); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[3];
    logic [DW-1:0] seen[$];
    int budget;
    sel = 0;
    do_reset();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < C; c++) d[i][c*W +: W] = $urandom;
    out_ready = 1'b0; in_valid = 1'b1; in_data = d[0];
    cyc();
    in_data = d[1];
    #1;
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b got %b want 1", ir); end
    cyc();
    in_data = d[2];
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (ir !== 1'b0 || occ !== 2'd2) begin n_fail++; $display("FAIL bp_full got rdy=%b occ=%0d want rdy=0 occ=2", ir, occ); end
      n_checks++; if (od !== d[0]) begin n_fail++; $display("FAIL bp_head_stable got %h want %h", od, d[0]); end
      cyc();
    end
    out_ready = 1'b1;
    budget = 0;
    while (seen.size() < 3 && budget < 10) begin
      #1;
      if (ov) seen.push_back(od);
      if (in_valid && ir) begin
        cyc();
        in_valid = 1'b0;
      end else begin
        cyc();
      end
      budget++;
    end
    n_checks++; if (seen.size() != 3) begin n_fail++; $display("FAIL bp_drain_count got %0d want 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_checks++; if (seen[i] !== d[i]) begin n_fail++; $display("FAIL bp_order i=%0d got %h want %h", i, seen[i], d[i]); end
    end
    n_checks++; if (sc !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt got %0d want 3", sc); end
  endtask

  task automatic test_flush();
    sel = 0;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = {C{32'h1111_1111}};
    cyc();
    in_data = {C{32'h2222_2222}};
    cyc();
    in_data = {C{32'h3333_3333}}; flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    n_checks++; if (ov !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL flush_empty got v=%b occ=%0d want v=0 occ=0", ov, occ); end
    n_checks++; if (od !== '0) begin n_fail++; $display("FAIL flush_data got %h want 0", od); end
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", ir); end
    n_checks++; if (sc !== 16'd2) begin n_fail++; $display("FAIL flush_stall_kept got %0d want 2", sc); end
    in_valid = 1'b0;
    cyc();
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got %b want 0", ov); end
  endtask

  task automatic test_saturation();
    sel = 2;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = {C{32'h5A5A_5A5A}};
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      n_checks++; if (sc !== 16'(m_stall) || ov !== 1'b1) begin n_fail++; $display("FAIL sat_step i=%0d got cnt=%0d v=%b want cnt=%0d v=1", i, sc, ov, m_stall); end
    end
    n_checks++; if (sc !== 16'd15) begin n_fail++; $display("FAIL sat_final got %0d want 15", sc); end
  endtask

  task automatic test_channels();
    sel = 0;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < C; k++) in_data[k*W +: W] = {4{4'(k), 4'h0}};
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < C; k++) begin
      n_checks++; if (od[k*W +: W] !== 32'(k) * 32'h1010_1010) begin n_fail++; $display("FAIL chan_%0d got %h want %h", k, od[k*W +: W], 32'(k) * 32'h1010_1010); end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int n = 0; n < 400; n++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 31) == 0);
        reset     = ($urandom_range(0, 99) == 0);
        for (int c = 0; c < C; c++) in_data[c*W +: W] = $urandom;
        #1;
        if (!reset) begin
          n_checks++; if (ir !== model_ready()) begin n_fail++; $display("FAIL rnd_in_ready sel=%0d n=%0d got %b want %b", s, n, ir, model_ready()); end
        end
        cyc();
        n_checks++; if (ov !== (q.size() > 0) || occ !== 2'(q.size())) begin n_fail++; $display("FAIL rnd_valid_occ sel=%0d n=%0d got v=%b occ=%0d want occ=%0d", s, n, ov, occ, q.size()); end
        n_checks++; if (sc !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall sel=%0d n=%0d got %0d want %0d", s, n, sc, m_stall); end
        if (q.size() > 0) begin
          n_checks++; if (od !== q[0]) begin n_fail++; $display("FAIL rnd_data sel=%0d n=%0d got %h want %h", s, n, od, q[0]); end
        end else if (m_zero) begin
          n_checks++; if (od !== '0) begin n_fail++; $display("FAIL rnd_zero sel=%0d n=%0d got %h want 0", s, n, od); end
        end
      end
      reset = 1'b0; flush = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_channels();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
